alu_op_sequencer: RTL and testbench

Upstream issue stage for the 256-bit bit-manipulation ALU (PARITY, ROTR, ROTL, POPCOUNT).
- Accepts operation requests (opcode, A, B) over a valid/ready interface and buffers them in a small FIFO.
- Drives one request at a time onto the ALU's opcode/A_in/B_in inputs and holds them stable for the ALU's registered latency.
- Captures Alu_out and presents it downstream with a valid/ready handshake. Illegal opcodes are flagged without using the ALU.

---
 rtl/alu_op_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Issue stage for the 256-bit bit-manipulation ALU: buffers requests in a small FIFO,
// issues one at a time, waits out the ALU latency and presents each result downstream.
module alu_op_sequencer #(
    parameter int DATA_WIDTH  = 256,
    parameter int FIFO_DEPTH  = 4,
    parameter int ALU_LATENCY = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [2:0]                        in_opcode,
    input  logic [DATA_WIDTH-1:0]             in_a,
    input  logic [DATA_WIDTH-1:0]             in_b,
    output logic [2:0]                        alu_opcode,
    output logic [DATA_WIDTH-1:0]             alu_a,
    output logic [DATA_WIDTH-1:0]             alu_b,
    input  logic [DATA_WIDTH-1:0]             alu_result,
    output logic                              res_valid,
    input  logic                              res_ready,
    output logic [DATA_WIDTH-1:0]             res_data,
    output logic [2:0]                        res_opcode,
    output logic                              res_err,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int WAIT_W  = $clog2(ALU_LATENCY + 1);
    localparam int ENTRY_W = 3 + 2 * DATA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t                  state_reg, state_next;
    logic [WAIT_W-1:0]       wait_reg, wait_next;
    logic [PTR_W-1:0]        rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0]        wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0]        count_reg, count_next;
    logic [2:0]              alu_opcode_reg, alu_opcode_next;
    logic [DATA_WIDTH-1:0]   alu_a_reg, alu_a_next;
    logic [DATA_WIDTH-1:0]   alu_b_reg, alu_b_next;
    logic                    res_valid_reg, res_valid_next;
    logic [DATA_WIDTH-1:0]   res_data_reg, res_data_next;
    logic [2:0]              res_opcode_reg, res_opcode_next;
    logic                    res_err_reg, res_err_next;

    logic                    push;
    logic                    pop;
    logic [ENTRY_W-1:0]      entry_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0]      head;
    logic [2:0]              head_op;
    logic [DATA_WIDTH-1:0]   head_a;
    logic [DATA_WIDTH-1:0]   head_b;

    // Ready comes only from the registered count, never from the pop path.
    assign in_ready = (count_reg != CNT_W'(FIFO_DEPTH));
    assign push     = in_valid && in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            logic [ENTRY_W-1:0] entry_reg;
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    entry_reg <= {in_opcode, in_a, in_b};
                end
            end
            assign entry_q[gi] = entry_reg;
        end
    endgenerate

    assign head    = entry_q[rd_ptr_reg];
    assign head_op = head[ENTRY_W-1 -: 3];
    assign head_a  = head[2*DATA_WIDTH-1 -: DATA_WIDTH];
    assign head_b  = head[DATA_WIDTH-1:0];

    always_comb begin
        rd_ptr_next = pop  ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;
        wr_ptr_next = push ? wr_ptr_reg + PTR_W'(1) : wr_ptr_reg;
        count_next  = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_comb begin
        state_next      = state_reg;
        wait_next       = wait_reg;
        alu_opcode_next = alu_opcode_reg;
        alu_a_next      = alu_a_reg;
        alu_b_next      = alu_b_reg;
        res_valid_next  = res_valid_reg;
        res_data_next   = res_data_reg;
        res_opcode_next = res_opcode_reg;
        res_err_next    = res_err_reg;
        pop             = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (count_reg != '0) begin
                    pop = 1'b1;
                end
            end
            S_WAIT: begin
                if (wait_reg != '0) begin
                    wait_next = wait_reg - WAIT_W'(1);
                end else begin
                    res_data_next   = alu_result;
                    res_opcode_next = alu_opcode_reg;
                    res_err_next    = 1'b0;
                    res_valid_next  = 1'b1;
                    state_next      = S_HOLD;
                end
            end
            S_HOLD: begin
                if (res_ready) begin
                    res_valid_next = 1'b0;
                    if (count_reg != '0) begin
                        pop = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase

        // Shared issue path for IDLE and back-to-back pops from HOLD.
        if (pop) begin
            if (!head_op[2]) begin
                alu_opcode_next = head_op;
                alu_a_next      = head_a;
                alu_b_next      = head_b;
                wait_next       = WAIT_W'(ALU_LATENCY);
                state_next      = S_WAIT;
            end else begin
                res_data_next   = '0;
                res_opcode_next = head_op;
                res_err_next    = 1'b1;
                res_valid_next  = 1'b1;
                state_next      = S_HOLD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            wait_reg       <= '0;
            rd_ptr_reg     <= '0;
            wr_ptr_reg     <= '0;
            count_reg      <= '0;
            alu_opcode_reg <= '0;
            alu_a_reg      <= '0;
            alu_b_reg      <= '0;
            res_valid_reg  <= 1'b0;
            res_data_reg   <= '0;
            res_opcode_reg <= '0;
            res_err_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            wait_reg       <= wait_next;
            rd_ptr_reg     <= rd_ptr_next;
            wr_ptr_reg     <= wr_ptr_next;
            count_reg      <= count_next;
            alu_opcode_reg <= alu_opcode_next;
            alu_a_reg      <= alu_a_next;
            alu_b_reg      <= alu_b_next;
            res_valid_reg  <= res_valid_next;
            res_data_reg   <= res_data_next;
            res_opcode_reg <= res_opcode_next;
            res_err_reg    <= res_err_next;
        end
    end

    assign alu_opcode = alu_opcode_reg;
    assign alu_a      = alu_a_reg;
    assign alu_b      = alu_b_reg;
    assign res_valid  = res_valid_reg;
    assign res_data   = res_data_reg;
    assign res_opcode = res_opcode_reg;
    assign res_err    = res_err_reg;
    assign fifo_count = count_reg;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: an ALU stand-in plus a result-queue reference model
// compares every delivered result, with scenario tasks checking timing and boundaries.
module tb_alu_op_sequencer;
    localparam int DW    = 256;
    localparam int DEPTH = 4;
    localparam int LAT   = 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2:0]      in_opcode = '0;
    logic [DW-1:0]   in_a = '0;
    logic [DW-1:0]   in_b = '0;
    logic [2:0]      alu_opcode;
    logic [DW-1:0]   alu_a;
    logic [DW-1:0]   alu_b;
    logic [DW-1:0]   alu_result = '0;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [DW-1:0]   res_data;
    logic [2:0]      res_opcode;
    logic            res_err;
    logic [2:0]      fifo_count;

    typedef struct packed {
        logic [2:0]    op;
        logic          err;
        logic [DW-1:0] data;
    } res_t;

    res_t          exp_q[$];
    res_t          got_q[$];
    int            n_checks = 0;
    int            n_fail = 0;
    logic [2:0]    last_op = '0;
    logic [DW-1:0] last_a = '0;
    logic [DW-1:0] last_b = '0;
    bit            rand_done = 1'b0;

    alu_op_sequencer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ALU_LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_a(in_a), .in_b(in_b),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_opcode(res_opcode), .res_err(res_err), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // What the ALU should produce for a request, straight from the operation definitions.
    function automatic res_t ref_model(input logic [2:0] op, input logic [DW-1:0] a,
                                       input logic [DW-1:0] b);
        res_t          r;
        logic [2*DW-1:0] t;
        int            s;
        s      = int'(b[7:0]);
        r.op   = op;
        r.err  = 1'b0;
        r.data = '0;
        case (op)
            3'd0: r.data[0] = ^a;
            3'd1: begin t = {a, a} >> s; r.data = t[DW-1:0]; end
            3'd2: begin t = {a, a} << s; r.data = t[2*DW-1:DW]; end
            3'd3: r.data = DW'($countones(a));
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic [DW-1:0] rand256();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    // Registered ALU stand-in with one edge of latency.
    always @(posedge clk) alu_result <= ref_model(alu_opcode, alu_a, alu_b).data;

    // Record accepted requests (as expected results) and delivered results.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_model(in_opcode, in_a, in_b));
                if (!in_opcode[2]) begin
                    last_op <= in_opcode;
                    last_a  <= in_a;
                    last_b  <= in_b;
                end
            end
            if (res_valid && res_ready) begin
                got_q.push_back(res_t'({res_opcode, res_err, res_data}));
                $display("result op=%0d err=%b data=%h", res_opcode, res_err, res_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        in_valid  = 1'b1;
        in_opcode = op;
        in_a      = a;
        in_b      = b;
        for (int i = 0; i < 100; i++) begin
            if (in_ready) begin
                tick();
                in_valid = 1'b0;
                return;
            end
            tick();
        end
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: in_ready stayed 0, required 1 within 100 cycles");
        in_valid = 1'b0;
    endtask

    task automatic wait_results(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (got_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1;
        in_opcode = 3'($urandom_range(0, 7));
        in_a = rand256();
        tick();
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1 || fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: res_valid=%b in_ready=%b fifo_count=%0d, required 0 1 0",
                     res_valid, in_ready, fifo_count);
        end
        n_checks++;
        if (alu_opcode !== 3'd0 || alu_a !== '0 || alu_b !== '0) begin
            n_fail++;
            $display("FAIL reset_alu: alu_opcode=%0d alu_a=%h alu_b=%h, required all 0",
                     alu_opcode, alu_a, alu_b);
        end
        n_checks++;
        if (res_data !== '0 || res_opcode !== 3'd0 || res_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_res: res_data=%h res_opcode=%0d res_err=%b, required all 0",
                     res_data, res_opcode, res_err);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_parity();
        res_t g, e;
        bit   ok;
        int   rise;
        res_ready = 1'b1;
        send(3'd0, DW'(8'hAC), rand256());
        in_valid = 1'b1; in_opcode = 3'd0; in_a = DW'(8'hAD); in_b = rand256();
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_early: res_valid=%b at pop edge, required 0", res_valid);
        end
        rise = 0;
        for (int n = 2; n <= 10; n++) begin
            tick();
            if (res_valid) begin rise = n; break; end
        end
        n_checks++;
        if (rise != 3) begin
            n_fail++;
            $display("FAIL parity_latency: res_valid rose %0d edges after push, required 3", rise);
        end
        wait_results(2, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL parity_timeout: got %0d results, required 2", got_q.size());
        end else begin
            n_checks++;
            if (got_q[0].data !== DW'(0) || got_q[1].data !== DW'(1)) begin
                n_fail++;
                $display("FAIL parity_values: got %0d then %0d, required 0 then 1",
                         got_q[0].data, got_q[1].data);
            end
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL parity_model: got op=%0d err=%b data=%h, required op=%0d err=%b data=%h",
                         g.op, g.err, g.data, e.op, e.err, e.data);
            end
        end
    endtask

    task automatic test_popcount();
        res_t g, e;
        bit   ok;
        int   rise;
        res_ready = 1'b1;
        send(3'd3, DW'(8'hED), rand256());
        rise = 0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            n_checks++;
            if (alu_a !== DW'(8'hED) || alu_opcode !== 3'd3) begin
                n_fail++;
                $display("FAIL popcount_hold: alu_opcode=%0d alu_a=%h, required 3 and ed", alu_opcode, alu_a);
            end
            if (res_valid) begin rise = n; break; end
        end
        n_checks++;
        if (rise != 3 || res_data !== DW'(6) || res_opcode !== 3'd3 || res_err !== 1'b0) begin
            n_fail++;
            $display("FAIL popcount_result: rise=%0d data=%0d op=%0d err=%b, required 3 6 3 0",
                     rise, res_data, res_opcode, res_err);
        end
        wait_results(1, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL popcount_timeout: got %0d results, required 1", got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL popcount_model: got op=%0d err=%b data=%h, required op=%0d err=%b data=%h",
                         g.op, g.err, g.data, e.op, e.err, e.data);
            end
        end
    endtask

    task automatic test_rotate();
        res_t          g, e;
        bit            ok;
        logic [DW-1:0] want_r, want_l, a_top;
        want_r = DW'(8'h15) | (DW'(3'h5) << 253);
        want_l = DW'(8'h05) | (DW'(8'h68) << 248);
        a_top  = DW'(8'hAD) << 248;
        res_ready = 1'b1;
        send(3'd1, DW'(8'hAD), DW'(3));
        send(3'd2, a_top, DW'(3));
        wait_results(2, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rotate_timeout: got %0d results, required 2", got_q.size());
        end else begin
            n_checks++;
            if (got_q[0].data !== want_r || got_q[1].data !== want_l) begin
                n_fail++;
                $display("FAIL rotate_values: got %h / %h, required %h / %h",
                         got_q[0].data, got_q[1].data, want_r, want_l);
            end
        end
        for (int i = 0; i < 6; i++) send(3'($urandom_range(1, 2)), rand256(), rand256());
        send(3'd2, a_top, DW'(3));
        wait_results(9, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rotate_rand_timeout: got %0d results, required 9", got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL rotate_model: got op=%0d err=%b data=%h, required op=%0d err=%b data=%h",
                         g.op, g.err, g.data, e.op, e.err, e.data);
            end
        end
    endtask

    task automatic test_illegal();
        res_t g, e;
        bit   ok;
        res_ready = 1'b0;
        send(3'd7, rand256(), rand256());
        n_checks++;
        if (res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_early: res_valid=%b before pop, required 0", res_valid);
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (res_valid !== 1'b1 || res_err !== 1'b1 || res_data !== '0 || res_opcode !== 3'd7) begin
                n_fail++;
                $display("FAIL illegal_result: valid=%b err=%b data=%h op=%0d, required 1 1 0 7",
                         res_valid, res_err, res_data, res_opcode);
            end
            n_checks++;
            if (alu_opcode !== last_op || alu_a !== last_a || alu_b !== last_b) begin
                n_fail++;
                $display("FAIL illegal_alu: alu_opcode=%0d alu_a=%h, required %0d %h",
                         alu_opcode, alu_a, last_op, last_a);
            end
            tick();
        end
        res_ready = 1'b1;
        send(3'($urandom_range(4, 6)), rand256(), rand256());
        send(3'($urandom_range(4, 6)), rand256(), rand256());
        wait_results(3, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL illegal_timeout: got %0d results, required 3", got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL illegal_model: got op=%0d err=%b data=%h, required op=%0d err=%b data=%h",
                         g.op, g.err, g.data, e.op, e.err, e.data);
            end
        end
    endtask

    task automatic test_back_to_back();
        res_t          g, e;
        logic [2:0]    ops [6];
        logic [DW-1:0] as [6];
        logic [DW-1:0] bs [6];
        int            acc;
        int            cyc;
        bit            rdy;
        for (int i = 0; i < 6; i++) begin
            ops[i] = 3'($urandom_range(0, 7));
            as[i]  = rand256();
            bs[i]  = rand256();
        end
        res_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            if (acc < 6) begin
                in_valid = 1'b1; in_opcode = ops[acc]; in_a = as[acc]; in_b = bs[acc];
            end else begin
                in_valid = 1'b0;
            end
            rdy = in_ready;
            tick();
            if (rdy && acc < 6) acc++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (acc != 5 || in_ready !== 1'b0 || fifo_count !== 3'd4) begin
            n_fail++;
            $display("FAIL full_fifo: accepted=%0d in_ready=%b fifo_count=%0d, required 5 0 4",
                     acc, in_ready, fifo_count);
        end
        res_ready = 1'b1;
        cyc = 0;
        while (got_q.size() < 5 && cyc < 100) begin
            tick();
            cyc++;
        end
        n_checks++;
        if (got_q.size() < 5 || cyc > 5 * (LAT + 2)) begin
            n_fail++;
            $display("FAIL drain_rate: %0d results in %0d cycles, required 5 within %0d",
                     got_q.size(), cyc, 5 * (LAT + 2));
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL drain_model: got op=%0d err=%b data=%h, required op=%0d err=%b data=%h",
                         g.op, g.err, g.data, e.op, e.err, e.data);
            end
        end
    endtask

    task automatic test_reset_midflight();
        res_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(3'($urandom_range(0, 3)), rand256(), rand256());
        n_checks++;
        if (fifo_count !== 3'd2 || res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midflight_setup: fifo_count=%0d res_valid=%b, required 2 0", fifo_count, res_valid);
        end
        rst_n = 1'b0;
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        n_checks++;
        if (res_valid !== 1'b0 || fifo_count !== 3'd0 || in_ready !== 1'b1 || alu_a !== '0) begin
            n_fail++;
            $display("FAIL midflight_reset: res_valid=%b fifo_count=%0d in_ready=%b alu_a=%h, required 0 0 1 0",
                     res_valid, fifo_count, in_ready, alu_a);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (res_valid !== 1'b0 || got_q.size() != 0) begin
                n_fail++;
                $display("FAIL stale_result: res_valid=%b results=%0d, required 0 0", res_valid, got_q.size());
            end
        end
        got_q.delete();
    endtask

    task automatic test_random();
        res_t g, e;
        bit   ok;
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    send(3'($urandom_range(0, 7)), rand256(), rand256());
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    res_ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        res_ready = 1'b1;
        wait_results(40, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL random_timeout: got %0d results, required 40", got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL random_model: got op=%0d err=%b data=%h, required op=%0d err=%b data=%h",
                         g.op, g.err, g.data, e.op, e.err, e.data);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_parity();
        test_popcount();
        test_rotate();
        test_illegal();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
